// File: rtl/dp_rx_pkg.sv
// Shared definitions for the DP receive controller: read FSM states,
// default sizing and packet field positions.
package dp_rx_pkg;

  localparam int DEF_DEPTH   = 16;
  localparam int DEF_MSG_LEN = 5;

  localparam int DST_MSB = 31;
  localparam int DST_LSB = 16;
  localparam int PLD_MSB = 15;
  localparam int PLD_LSB = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RETURN = 2'd2
  } rd_state_e;

  function automatic logic is_for_node(input logic [31:0] pkt, input logic [15:0] id);
    return pkt[DST_MSB:DST_LSB] == id;
  endfunction

endpackage

// File: rtl/dp_rx_ptr.sv
// Wrapping buffer pointer; wraps naturally because the buffer depth is a
// power of two and the pointer is exactly log2(depth) bits wide.
module dp_rx_ptr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clr_n_i,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = ptr_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!clr_n_i) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/dp_rx_controller.sv
// Receive controller: filters packets by node id into a circular RAM FIFO
// and serves single-word GPP reads; writes always win the RAM port.
module dp_rx_controller
  import dp_rx_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int MSG_LEN = DEF_MSG_LEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              node_id,
  input  logic [31:0]              rx_packet,
  input  logic                     rx_valid,
  input  logic                     gpp_rd_req,
  output logic [15:0]              gpp_rd_data,
  output logic                     gpp_rd_valid,
  output logic                     ram_we,
  output logic [$clog2(DEPTH)-1:0] ram_addr,
  output logic [15:0]              ram_wdata,
  input  logic [15:0]              ram_rdata,
  output logic                     empty,
  output logic                     full,
  output logic                     rx_complete,
  output logic                     rx_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int MW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

  logic [15:0]   hold_q,     hold_d;
  logic          hold_vld_q, hold_vld_d;
  logic [CW-1:0] occ_q,      occ_d;
  logic [MW-1:0] msg_q,      msg_d;
  logic          ovf_q,      ovf_d;
  rd_state_e     state_q;
  logic          pend_q;

  logic          accept;
  logic          do_write;
  logic          do_drop;
  logic          do_read;
  logic          msg_last;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign accept   = rx_valid && is_for_node(rx_packet, node_id);
  assign empty    = (occ_q == '0);
  assign full     = (occ_q == CW'(DEPTH));
  assign do_write = hold_vld_q && !full;
  assign do_drop  = hold_vld_q && full;
  // A dropped word does not occupy the RAM port, so a read may still issue.
  assign do_read  = (state_q == ISSUE) && !do_write;
  assign msg_last = (msg_q == MW'(MSG_LEN - 1));

  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = accept;
    if (accept) hold_d = rx_packet[PLD_MSB:PLD_LSB];

    occ_d = occ_q;
    unique case ({do_write, do_read})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase

    msg_d = msg_q;
    if (hold_vld_q) msg_d = msg_last ? '0 : msg_q + MW'(1);

    ovf_d = ovf_q | do_drop;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      occ_q      <= '0;
      msg_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      occ_q      <= occ_d;
      msg_q      <= msg_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE:    if (pend_q && !empty) state_q <= ISSUE;
        ISSUE:   if (do_read) state_q <= RETURN;
        RETURN:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (do_read)         pend_q <= 1'b0;
      else if (gpp_rd_req) pend_q <= 1'b1;
    end
  end

  dp_rx_ptr #(.W(AW)) u_wr_ptr (
    .clk     (clk),
    .clr_n_i (rst),
    .inc_i   (do_write),
    .ptr_o   (wr_ptr)
  );

  dp_rx_ptr #(.W(AW)) u_rd_ptr (
    .clk     (clk),
    .clr_n_i (rst),
    .inc_i   (do_read),
    .ptr_o   (rd_ptr)
  );

  assign ram_we       = do_write;
  assign ram_addr     = do_read ? rd_ptr : wr_ptr;
  assign ram_wdata    = hold_q;
  assign rx_complete  = hold_vld_q && msg_last;
  assign rx_overflow  = ovf_q;
  assign gpp_rd_valid = (state_q == RETURN);
  assign gpp_rd_data  = gpp_rd_valid ? ram_rdata : '0;

endmodule

// File: tb/tb_dp_rx_controller.sv
// Bench for dp_rx_controller: directed scenarios plus a randomized packet
// stream, checked against a queue-level model of the receive buffer.
module tb_dp_rx_controller;

  localparam int DEPTH   = 16;
  localparam int MSG_LEN = 5;
  localparam int AW      = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   node_id;
  logic [31:0]   rx_packet;
  logic          rx_valid;
  logic          gpp_rd_req;
  logic [15:0]   gpp_rd_data;
  logic          gpp_rd_valid;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_wdata;
  logic [15:0]   ram_rdata;
  logic          empty;
  logic          full;
  logic          rx_complete;
  logic          rx_overflow;

  int vectors     = 0;
  int miscompares = 0;

  dp_rx_controller #(.DEPTH(DEPTH), .MSG_LEN(MSG_LEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .node_id      (node_id),
    .rx_packet    (rx_packet),
    .rx_valid     (rx_valid),
    .gpp_rd_req   (gpp_rd_req),
    .gpp_rd_data  (gpp_rd_data),
    .gpp_rd_valid (gpp_rd_valid),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .empty        (empty),
    .full         (full),
    .rx_complete  (rx_complete),
    .rx_overflow  (rx_overflow)
  );

  always #5 clk = ~clk;

  // Single-port RAM, one-cycle read latency.
  logic [15:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Observed activity, sampled mid-cycle.
  logic [19:0] wr_log[$];
  int cplt_cnt     = 0;
  int cplt_idx     = -1;
  int rd_valid_cnt = 0;
  always @(negedge clk) begin
    if (ram_we) wr_log.push_back({ram_addr, ram_wdata});
    if (rx_complete) begin
      cplt_cnt++;
      cplt_idx = wr_log.size();
    end
    if (gpp_rd_valid) rd_valid_cnt++;
  end

  // Reference model: FIFO contents, expected write stream, message count.
  logic [15:0] model_q[$];
  logic [19:0] exp_wr[$];
  int   acc_cnt;
  int   exp_cplt;
  int   model_waddr;
  logic exp_ovf;

  task automatic model_reset();
    model_q.delete();
    exp_wr.delete();
    wr_log.delete();
    acc_cnt     = 0;
    exp_cplt    = 0;
    cplt_cnt    = 0;
    model_waddr = 0;
    exp_ovf     = 1'b0;
  endtask

  task automatic model_pkt(input logic [31:0] pkt);
    if (pkt[31:16] == node_id) begin
      acc_cnt++;
      if (acc_cnt % MSG_LEN == 0) exp_cplt++;
      if (model_q.size() < DEPTH) begin
        model_q.push_back(pkt[15:0]);
        exp_wr.push_back({AW'(model_waddr), pkt[15:0]});
        model_waddr = (model_waddr + 1) % DEPTH;
      end else begin
        exp_ovf = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [31:0] pkt);
    rx_packet = pkt;
    rx_valid  = 1'b1;
    model_pkt(pkt);
    step();
    rx_valid  = 1'b0;
  endtask

  task automatic check_writes(input string tag);
    int n;
    chk({tag, "_wr_count"}, 32'(wr_log.size()), 32'(exp_wr.size()));
    n = (wr_log.size() < exp_wr.size()) ? wr_log.size() : exp_wr.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_wr%0d", tag, i), 32'(wr_log[i]), 32'(exp_wr[i]));
    chk({tag, "_cplt"}, 32'(cplt_cnt), 32'(exp_cplt));
    wr_log.delete();
    exp_wr.delete();
  endtask

  task automatic wait_valid(input string tag);
    logic [15:0] expv;
    bit got;
    got  = 1'b0;
    expv = 16'h0;
    if (model_q.size() > 0) expv = model_q.pop_front();
    for (int i = 0; i < 20; i++) begin
      if (gpp_rd_valid) begin
        got = 1'b1;
        break;
      end
      step();
    end
    chk({tag, "_valid"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, "_data"}, 32'(gpp_rd_data), 32'(expv));
      step();
    end
  endtask

  task automatic do_read(input string tag);
    gpp_rd_req = 1'b1;
    step();
    gpp_rd_req = 1'b0;
    wait_valid(tag);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int saved;
    logic [15:0] dst;
    rst        = 1'b0;
    rx_valid   = 1'b0;
    gpp_rd_req = 1'b0;
    rx_packet  = 32'h0;
    node_id    = 16'h0003;
    model_reset();
    step();
    step();
    step();

    // Reset state
    chk("rst_empty",    32'(empty),        32'd1);
    chk("rst_full",     32'(full),         32'd0);
    chk("rst_addr",     32'(ram_addr),     32'd0);
    chk("rst_rd_data",  32'(gpp_rd_data),  32'd0);
    chk("rst_rd_valid", 32'(gpp_rd_valid), 32'd0);
    chk("rst_ovf",      32'(rx_overflow),  32'd0);
    chk("rst_cplt",     32'(rx_complete),  32'd0);
    chk("rst_we",       32'(ram_we),       32'd0);
    rst = 1'b1;
    step();

    // Foreign packet: ignored, message count untouched
    send(32'h0007_1234);
    chk("foreign_we", 32'(ram_we), 32'd0);
    step();
    check_writes("foreign");

    // Five matching packets back-to-back
    for (int i = 0; i < 5; i++) send(32'h0003_00A0 + 32'(i));
    step();
    check_writes("msg5");
    chk("msg5_cplt_at_5th", 32'(cplt_idx), 32'd5);
    chk("msg5_empty", 32'(empty), 32'd0);
    chk("msg5_full",  32'(full),  32'd0);

    // Read them back in order
    for (int i = 0; i < 5; i++) do_read($sformatf("rd5_%0d", i));
    chk("rd5_empty", 32'(empty), 32'd1);

    // Fill, overflow, then wrap
    do_reset();
    for (int i = 0; i < 17; i++) send(32'h0003_0100 + 32'(i));
    step();
    check_writes("fill");
    chk("fill_full",  32'(full),        32'd1);
    chk("fill_ovf",   32'(rx_overflow), 32'(exp_ovf));
    chk("fill_wrptr", 32'(ram_addr),    32'd0);
    do_read("fill_rd");
    chk("fill_rd_notfull", 32'(full), 32'd0);
    send(32'h0003_F00D);
    step();
    check_writes("wrap");
    chk("wrap_full", 32'(full), 32'd1);
    while (model_q.size() > 0) do_read($sformatf("drain_%0d", model_q.size()));
    chk("drain_empty", 32'(empty), 32'd1);

    // Read requested while empty, serviced after the next write
    saved = rd_valid_cnt;
    gpp_rd_req = 1'b1;
    step();
    gpp_rd_req = 1'b0;
    repeat (5) step();
    chk("pend_no_early_valid", 32'(rd_valid_cnt), 32'(saved));
    send(32'h0003_BEEF);
    wait_valid("pend_rd");
    check_writes("pend");

    // Reset during ISSUE discards the read
    send(32'h0003_5555);
    step();
    check_writes("pre_issue");
    gpp_rd_req = 1'b1;
    step();
    gpp_rd_req = 1'b0;
    step();
    rst   = 1'b0;
    saved = rd_valid_cnt;
    step();
    chk("issue_rst_valid", 32'(gpp_rd_valid), 32'd0);
    chk("issue_rst_empty", 32'(empty),        32'd1);
    chk("issue_rst_ovf",   32'(rx_overflow),  32'd0);
    rst = 1'b1;
    model_reset();
    repeat (4) step();
    chk("issue_rst_no_pulse", 32'(rd_valid_cnt), 32'(saved));

    // Randomized stream with foreign traffic and possible overflow
    for (int i = 0; i < 30; i++) begin
      dst = ($urandom_range(0, 9) < 6) ? 16'h0003 : 16'($urandom_range(4, 16'hFFFF));
      send({dst, 16'($urandom)});
      repeat ($urandom_range(0, 2)) step();
    end
    step();
    check_writes("rand");
    chk("rand_ovf",  32'(rx_overflow), 32'(exp_ovf));
    chk("rand_full", 32'(full),        32'(model_q.size() == DEPTH));
    while (model_q.size() > 0) do_read($sformatf("rand_rd_%0d", model_q.size()));
    chk("rand_empty", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dp_rx_controller.md
DP_RX_CONTROLLER -- requirements
Module: dp_rx_controller

Interface
REQ-001 SHALL have parameter DEPTH, default 16: receive buffer depth in 16-bit words, power of two.
REQ-002 SHALL have parameter MSG_LEN, default 5: matched packets per message.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port node_id, input, 16 bits: this node's id.
REQ-006 SHALL have port rx_packet, input, 32 bits: [31:16] destination id, [15:0] payload.
REQ-007 SHALL have port rx_valid, input, 1 bit: rx_packet is valid this cycle; the port cannot be stalled.
REQ-008 SHALL have port gpp_rd_req, input, 1 bit: single-cycle read request from the GPP.
REQ-009 SHALL have port gpp_rd_data, output, 16 bits: word returned to the GPP.
REQ-010 SHALL have port gpp_rd_valid, output, 1 bit: gpp_rd_data is valid this cycle.
REQ-011 SHALL have ports ram_we (output, 1), ram_addr (output, log2(DEPTH)), ram_wdata (output, 16) and ram_rdata (input, 16): a single-port RAM with one-cycle read latency.
REQ-012 SHALL have ports empty (output, 1) and full (output, 1): buffer occupancy status.
REQ-013 SHALL have port rx_complete, output, 1 bit: one-cycle pulse at the end of each message.
REQ-014 SHALL have port rx_overflow, output, 1 bit: sticky flag, set when a word is dropped.

Function
REQ-015 SHALL accept a packet in a cycle where rx_valid=1 and rx_packet[31:16]=node_id; all other packets SHALL be ignored.
REQ-016 SHALL capture an accepted payload into a hold register and write it in the next cycle (ram_we=1, ram_addr=wr_ptr, ram_wdata=hold).
REQ-017 SHALL operate the buffer as a circular FIFO: wr_ptr and rd_ptr wrap from DEPTH-1 to 0; occupancy runs 0..DEPTH.
REQ-018 SHALL drop an accepted word if the buffer is full in its write cycle: no RAM write, wr_ptr unchanged, rx_overflow set to 1.
REQ-019 SHALL count accepted packets, including dropped ones, modulo MSG_LEN.
REQ-020 SHALL pulse rx_complete for exactly one cycle, in the write cycle of the MSG_LEN-th packet, and clear the counter in the same cycle.
REQ-021 SHALL latch gpp_rd_req into a pending flag; further requests while the flag is set SHALL be ignored.
REQ-022 SHALL use the read FSM states IDLE, ISSUE and RETURN.
REQ-023 SHALL move IDLE->ISSUE when the pending flag is set and the buffer is not empty.
REQ-024 SHALL in ISSUE, when no write is due this cycle, drive ram_we=0 and ram_addr=rd_ptr, advance rd_ptr, clear the pending flag and go to RETURN; otherwise it SHALL stay in ISSUE.
REQ-025 SHALL in RETURN drive gpp_rd_valid=1 with gpp_rd_data=ram_rdata, then go to IDLE.
REQ-026 SHALL give writes priority over reads on the RAM port; under back-to-back accepted packets, reads SHALL wait.
REQ-027 SHALL allow a write during RETURN.
REQ-028 SHALL, when a write and a read-issue complete in the same cycle, leave occupancy unchanged.
REQ-029 SHALL hold a read request made while empty as pending and service it after the next write.
REQ-030 SHALL drive empty = (occupancy==0) and full = (occupancy==DEPTH) from registered state.

Reset
REQ-031 SHALL, when rst=0 at a clock edge, clear: pointers, occupancy, message counter, hold-valid, pending flag, rx_overflow, rx_complete, gpp_rd_valid and ram_we; FSM SHALL go to IDLE.
REQ-032 SHALL discard an in-flight read or write on a reset mid-operation; no gpp_rd_valid pulse SHALL follow the reset.
REQ-033 SHALL after reset read empty=1, full=0, ram_addr=0, gpp_rd_data=0.

Structure
REQ-034 SHALL place the FSM state enum, MSG_LEN/DEPTH defaults and the packet field bit positions in shared package dp_rx_pkg.
REQ-035 SHALL implement the wrapping pointer as sub-module dp_rx_ptr (parameterised width, increment enable, synchronous active-low clear), instantiated twice.

Verification
REQ-036 Bench SHALL cover: node_id=0x0003, five packets 0x0003_00A0..0x0003_00A4 on consecutive cycles -> writes to addresses 0..4, rx_complete single pulse with the fifth write, occupancy 5.
REQ-037 Bench SHALL cover: packet 0x0007_1234 with node_id=0x0003 -> no write, counter unchanged.
REQ-038 Bench SHALL cover: after REQ-036, five gpp_rd_req pulses -> gpp_rd_valid returns 0x00A0..0x00A4 in order, then empty=1.
REQ-039 Bench SHALL cover: fill 16 words, accept a 17th -> full=1, rx_overflow=1, word dropped, wr_ptr=0; then one read plus one write -> wrap write to address 0.
REQ-040 Bench SHALL cover: gpp_rd_req while empty, then one packet 0x0003_BEEF -> read issued after the write, gpp_rd_data=0xBEEF.
REQ-041 Bench SHALL cover: rst=0 during ISSUE -> no gpp_rd_valid, empty=1, rx_overflow=0 on the next cycle.
